aud_sram_arbiter: RTL and testbench
===================================

# aud_sram_arbiter

Two-port arbiter that shares the single off-chip 16-bit audio SRAM between the recorder (write port) and the playback DSP (read port). It sequences every SRAM access through a fixed-length bus cycle and returns read data to the player. It also tracks the end-of-recording address and flags end of file to the top controller, so the top controller can issue stop. It sits between the recorder/player blocks and the SRAM pins in the top-level audio system.

## Interface
- `ADDR_W`, default 20: SRAM word address width.
- `DATA_W`, default 16: SRAM data width.
- `ACC_CYC`, default 2: cycles the SRAM pins are held active per access; legal range 1–15.

- `i_clk`  in  1  system clock; all logic on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_rec_req`  in  1  single-cycle write request pulse.
- `i_rec_addr`  in  ADDR_W  write address; sampled with `i_rec_req`.
- `i_rec_wdata`  in  DATA_W  write data; sampled with `i_rec_req`.
- `o_rec_ack`  out  1  one-cycle pulse when the write completes.
- `i_play_req`  in  1  single-cycle read request pulse.
- `i_play_addr`  in  ADDR_W  read address; sampled with `i_play_req`.
- `o_play_rdata`  out  DATA_W  read data; valid from `o_play_ack` and held until the next read completes.
- `o_play_ack`  out  1  one-cycle pulse when the read completes.
- `o_play_eof`  out  1  pulses with `o_play_ack` when the read address is ≥ `o_rec_end_addr`.
- `i_clr_end`  in  1  clears `o_rec_end_addr` to 0.
- `o_rec_end_addr`  out  ADDR_W  one past the highest address written.
- `o_sram_addr`  out  ADDR_W  SRAM address pins.
- `o_sram_wdata`  out  DATA_W  write data to the pad.
- `o_sram_data_oe`  out  1  pad output enable; 1 during write accesses.
- `i_sram_rdata`  in  DATA_W  data from the pad.
- `o_sram_ce_n`, `o_sram_oe_n`, `o_sram_we_n`, `o_sram_lb_n`, `o_sram_ub_n`  out  1 each  active-low SRAM controls.

## Operation
- **Request capture**
  - A request pulse latches the address (and write data) into that port's holding register and sets the port's `pending` flag.
  - A pulse on a port that is already pending is dropped; the holding register is unchanged.
- **State machine**
  - States: `S_IDLE` and `S_ACCESS`.
  - `S_IDLE`: if any port is pending, grant one port, clear its `pending`, load the SRAM pin registers, zero the counter, and go to `S_ACCESS`.
  - `S_ACCESS`: increment the counter each cycle. On the cycle where counter = `ACC_CYC`-1:
    - capture `i_sram_rdata` if the access is a read;
    - register the ack for the granted port;
    - deassert all SRAM pins;
    - return to `S_IDLE`.
- **Arbitration**
  - Round-robin, using a `last_grant` flag.
  - When both ports are pending, grant the port that was not granted last.
  - `last_grant` resets to PLAY, so the first contended grant goes to REC.
- **Pin values during `S_ACCESS`**
  - Always: `ce_n`=0, `lb_n`=0, `ub_n`=0.
  - Read: `oe_n`=0, `we_n`=1, `data_oe`=0.
  - Write: `oe_n`=1, `we_n`=0, `data_oe`=1, `o_sram_wdata` = the captured data.
  - Outside `S_ACCESS`: all active-low controls are 1, `data_oe`=0, address and wdata hold their last value.
- **End address**
  - On each write ack: if addr ≥ `o_rec_end_addr`, set `o_rec_end_addr` = addr+1, truncated to `ADDR_W` bits (a write to the top address wraps it to 0).
  - `i_clr_end` overrides a same-cycle update.
- **EOF**: evaluated on the registered read address at ack time, using the `o_rec_end_addr` value in that cycle.
- **Reset**
  - All outputs go to 0, except the active-low controls, which go to 1.
  - `pending` flags clear; state returns to `S_IDLE`.
  - A reset during `S_ACCESS` aborts the access with no ack. The SRAM pins are inactive in the cycle after reset is sampled.

## Timing
- All outputs are registered.
- Uncontended request pulse at cycle t:
  - t+1: `pending` is set.
  - t+2 … t+1+`ACC_CYC`: SRAM pins active.
  - t+2+`ACC_CYC`: ack.
- The arbiter is in `S_IDLE` during the ack cycle, so the next access drives the pins from t+3+`ACC_CYC`.
- There is exactly one inactive bus cycle between back-to-back accesses.
- Throughput: one access per `ACC_CYC`+1 cycles.
- A pulse arriving in the same cycle as its own port's ack is accepted as a new request.

## Configuration
- `AUD_ARB_REC_PRIO_EN` defined: fixed priority. REC always wins a contended grant and `last_grant` is unused. This prevents record overruns at the cost of possible player starvation.
- Undefined: round-robin as described in Operation.

## Test plan
All scenarios use `ACC_CYC`=2.
- Reset → ce/oe/we/lb/ub_n = 1, `data_oe`=0, acks=0, `o_rec_end_addr`=0, `o_play_rdata`=0.
- Play pulse at cycle 0, addr 0x00010, `i_sram_rdata`=0x1234 → `oe_n`=0 and `o_sram_addr`=0x00010 in cycles 2–3; `o_play_ack`=1 in cycle 4; `o_play_rdata`=0x1234.
- Rec pulse, addr 0x00020, data 0xBEEF → `we_n`=0 and `data_oe`=1 in cycles 2–3 with wdata 0xBEEF; `o_rec_ack` in cycle 4; `o_rec_end_addr`=0x00021.
- Rec and play pulses in the same cycle 0 → rec ack in cycle 4, play ack in cycle 7. Repeated contention alternates grants; with the macro defined, REC wins every time.
- `o_rec_end_addr`=0x00021: read 0x00020 → `o_play_eof`=0; read 0x00021 → `o_play_eof`=1 with the ack. Then `i_clr_end` → `o_rec_end_addr`=0.
- Write issued at cycle 0, `i_rst` asserted in cycle 3 → controls inactive from cycle 4, no ack, `pending`=0. A new request afterwards completes normally.

Source files
------------

// File: rtl/aud_sram_arbiter.sv
// -----------------------------------------------------------------------------
// aud_sram_arbiter
// Shares one off-chip asynchronous 16-bit audio SRAM between the recorder
// (write port) and the playback DSP (read port).
//
// Each access occupies the SRAM pins for ACC_CYC cycles. Every access is
// followed by one idle bus cycle, which is also the cycle that carries the ack.
// The block also tracks the end-of-recording address (one past the highest
// word written) and flags end of file on reads at or beyond that address.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_rec_req/addr/wdata, o_rec_ack   recorder write request and completion
//   i_play_req/addr                   player read request
//   o_play_rdata/ack/eof              read data, completion and end-of-file
//   i_clr_end, o_rec_end_addr         end-of-recording address and its clear
//   o_sram_*, i_sram_rdata            SRAM pad interface (controls active low)
//
// Build option:
//   AUD_ARB_REC_PRIO_EN  when defined, REC always wins a contended grant
//                        (fixed priority). Otherwise grants are round-robin.
// -----------------------------------------------------------------------------
module aud_sram_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int ACC_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rec_req,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_wdata,
  output logic              o_rec_ack,
  input  logic              i_play_req,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [DATA_W-1:0] o_play_rdata,
  output logic              o_play_ack,
  output logic              o_play_eof,
  input  logic              i_clr_end,
  output logic [ADDR_W-1:0] o_rec_end_addr,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_data_oe,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_e;

  localparam logic [3:0]        ACC_LAST = 4'(ACC_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                is_wr_q, is_wr_d;
  logic                rec_pend_q, rec_pend_d;
  logic [ADDR_W-1:0]   rec_addr_q, rec_addr_d;
  logic [DATA_W-1:0]   rec_data_q, rec_data_d;
  logic                play_pend_q, play_pend_d;
  logic [ADDR_W-1:0]   play_addr_q, play_addr_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
  logic                data_oe_q, data_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                rec_ack_q, rec_ack_d;
  logic                play_ack_q, play_ack_d;
  logic                play_eof_q, play_eof_d;
  logic [DATA_W-1:0]   play_rdata_q, play_rdata_d;
  logic [ADDR_W-1:0]   rec_end_q, rec_end_d;
  logic [ADDR_W-1:0]   rec_end_upd_s;
  logic                grant_s;
  logic                pick_rec_s;
`ifndef AUD_ARB_REC_PRIO_EN
  // 1 when the last grant went to REC; reset value 0 means "PLAY last".
  logic                last_rec_q, last_rec_d;
`endif

  // Arbitration: which port wins if a grant happens this cycle.
  always_comb begin
    pick_rec_s = 1'b0;
`ifdef AUD_ARB_REC_PRIO_EN
    pick_rec_s = rec_pend_q;
`else
    if (rec_pend_q && play_pend_q) begin
      pick_rec_s = ~last_rec_q;
    end else begin
      pick_rec_s = rec_pend_q;
    end
    last_rec_d = last_rec_q;
    if (grant_s) begin
      last_rec_d = pick_rec_s;
    end else begin
      last_rec_d = last_rec_q;
    end
`endif
  end

  // Access sequencer, request capture and all next-state values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_wr_d       = is_wr_q;
    sram_addr_d   = sram_addr_q;
    sram_wdata_d  = sram_wdata_q;
    data_oe_d     = data_oe_q;
    ce_n_d        = ce_n_q;
    oe_n_d        = oe_n_q;
    we_n_d        = we_n_q;
    rec_ack_d     = 1'b0;
    play_ack_d    = 1'b0;
    play_eof_d    = 1'b0;
    play_rdata_d  = play_rdata_q;
    rec_end_upd_s = rec_end_q;
    grant_s       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rec_pend_q || play_pend_q) begin
          grant_s = 1'b1;
          is_wr_d = pick_rec_s;
          state_d = S_ACCESS;
          cnt_d   = 4'd0;
          ce_n_d  = 1'b0;
          if (pick_rec_s) begin
            sram_addr_d  = rec_addr_q;
            sram_wdata_d = rec_data_q;
            oe_n_d       = 1'b1;
            we_n_d       = 1'b0;
            data_oe_d    = 1'b1;
          end else begin
            sram_addr_d  = play_addr_q;
            sram_wdata_d = sram_wdata_q;
            oe_n_d       = 1'b0;
            we_n_d       = 1'b1;
            data_oe_d    = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == ACC_LAST) begin
          state_d   = S_IDLE;
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          data_oe_d = 1'b0;
          if (is_wr_q) begin
            rec_ack_d = 1'b1;
            // End address only ever grows; the +1 wraps at the top word.
            if (sram_addr_q >= rec_end_q) begin
              rec_end_upd_s = sram_addr_q + ADDR_ONE;
            end else begin
              rec_end_upd_s = rec_end_q;
            end
          end else begin
            play_ack_d   = 1'b1;
            play_rdata_d = i_sram_rdata;
            play_eof_d   = (sram_addr_q >= rec_end_q);
          end
        end else begin
          state_d = S_ACCESS;
        end
      end
      default: begin
        state_d   = S_IDLE;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        data_oe_d = 1'b0;
      end
    endcase

    rec_end_d = i_clr_end ? {ADDR_W{1'b0}} : rec_end_upd_s;

    // A pulse on a port whose request is still pending is dropped, including
    // the cycle in which that pending request is being granted.
    rec_pend_d = rec_pend_q;
    rec_addr_d = rec_addr_q;
    rec_data_d = rec_data_q;
    if (grant_s && pick_rec_s) begin
      rec_pend_d = 1'b0;
    end else if (i_rec_req && !rec_pend_q) begin
      rec_pend_d = 1'b1;
      rec_addr_d = i_rec_addr;
      rec_data_d = i_rec_wdata;
    end else begin
      rec_pend_d = rec_pend_q;
    end

    play_pend_d = play_pend_q;
    play_addr_d = play_addr_q;
    if (grant_s && !pick_rec_s) begin
      play_pend_d = 1'b0;
    end else if (i_play_req && !play_pend_q) begin
      play_pend_d = 1'b1;
      play_addr_d = i_play_addr;
    end else begin
      play_pend_d = play_pend_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      is_wr_q      <= 1'b0;
      rec_pend_q   <= 1'b0;
      rec_addr_q   <= {ADDR_W{1'b0}};
      rec_data_q   <= {DATA_W{1'b0}};
      play_pend_q  <= 1'b0;
      play_addr_q  <= {ADDR_W{1'b0}};
      sram_addr_q  <= {ADDR_W{1'b0}};
      sram_wdata_q <= {DATA_W{1'b0}};
      data_oe_q    <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      rec_ack_q    <= 1'b0;
      play_ack_q   <= 1'b0;
      play_eof_q   <= 1'b0;
      play_rdata_q <= {DATA_W{1'b0}};
      rec_end_q    <= {ADDR_W{1'b0}};
`ifndef AUD_ARB_REC_PRIO_EN
      last_rec_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_wr_q      <= is_wr_d;
      rec_pend_q   <= rec_pend_d;
      rec_addr_q   <= rec_addr_d;
      rec_data_q   <= rec_data_d;
      play_pend_q  <= play_pend_d;
      play_addr_q  <= play_addr_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      data_oe_q    <= data_oe_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      rec_ack_q    <= rec_ack_d;
      play_ack_q   <= play_ack_d;
      play_eof_q   <= play_eof_d;
      play_rdata_q <= play_rdata_d;
      rec_end_q    <= rec_end_d;
`ifndef AUD_ARB_REC_PRIO_EN
      last_rec_q   <= last_rec_d;
`endif
    end
  end

  assign o_rec_ack      = rec_ack_q;
  assign o_play_ack     = play_ack_q;
  assign o_play_eof     = play_eof_q;
  assign o_play_rdata   = play_rdata_q;
  assign o_rec_end_addr = rec_end_q;
  assign o_sram_addr    = sram_addr_q;
  assign o_sram_wdata   = sram_wdata_q;
  assign o_sram_data_oe = data_oe_q;
  // Byte lanes are always enabled together with chip enable.
  assign o_sram_ce_n    = ce_n_q;
  assign o_sram_lb_n    = ce_n_q;
  assign o_sram_ub_n    = ce_n_q;
  assign o_sram_oe_n    = oe_n_q;
  assign o_sram_we_n    = we_n_q;

endmodule

// File: tb/tb_aud_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aud_sram_arbiter
// Directed bench for aud_sram_arbiter with ACC_CYC = 2. "Cycle n" is the clock
// period following the n-th rising edge after a request pulse is raised;
// inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_aud_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rec_req;
  logic [19:0] rec_addr;
  logic [15:0] rec_wdata;
  logic        rec_ack;
  logic        play_req;
  logic [19:0] play_addr;
  logic [15:0] play_rdata;
  logic        play_ack;
  logic        play_eof;
  logic        clr_end;
  logic [19:0] rec_end;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_data_oe;
  logic [15:0] sram_rdata;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aud_sram_arbiter dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rec_req      (rec_req),
    .i_rec_addr     (rec_addr),
    .i_rec_wdata    (rec_wdata),
    .o_rec_ack      (rec_ack),
    .i_play_req     (play_req),
    .i_play_addr    (play_addr),
    .o_play_rdata   (play_rdata),
    .o_play_ack     (play_ack),
    .o_play_eof     (play_eof),
    .i_clr_end      (clr_end),
    .o_rec_end_addr (rec_end),
    .o_sram_addr    (sram_addr),
    .o_sram_wdata   (sram_wdata),
    .o_sram_data_oe (sram_data_oe),
    .i_sram_rdata   (sram_rdata),
    .o_sram_ce_n    (ce_n),
    .o_sram_oe_n    (oe_n),
    .o_sram_we_n    (we_n),
    .o_sram_lb_n    (lb_n),
    .o_sram_ub_n    (ub_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; rec_req = 1'b0; rec_addr = 20'h0; rec_wdata = 16'h0;
    play_req = 1'b0; play_addr = 20'h0; clr_end = 1'b0; sram_rdata = 16'h0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_ctrl_n", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    chk("rst_data_oe", {31'd0, sram_data_oe}, 32'h0);
    chk("rst_acks", {30'd0, rec_ack, play_ack}, 32'h0);
    chk("rst_end", {12'd0, rec_end}, 32'h0);
    chk("rst_rdata", {16'd0, play_rdata}, 32'h0);
    rst = 1'b0;
    tick();

    // Read of 0x00010 returning 0x1234
    sram_rdata = 16'h1234; play_addr = 20'h00010; play_req = 1'b1;
    tick(); play_req = 1'b0;                                         // c1
    chk("rd_c1_idle", {31'd0, ce_n}, 32'h1);
    tick();                                                          // c2
    chk("rd_c2_ctrl", {28'd0, ce_n, oe_n, we_n, sram_data_oe}, 32'h2);
    chk("rd_c2_addr", {12'd0, sram_addr}, 32'h00010);
    tick();                                                          // c3
    chk("rd_c3_oe", {31'd0, oe_n}, 32'h0);
    chk("rd_c3_ack", {31'd0, play_ack}, 32'h0);
    tick();                                                          // c4
    chk("rd_c4_ack", {31'd0, play_ack}, 32'h1);
    chk("rd_c4_rdata", {16'd0, play_rdata}, 32'h1234);
    chk("rd_c4_eof", {31'd0, play_eof}, 32'h1);
    chk("rd_c4_pins_off", {29'd0, ce_n, oe_n, we_n}, 32'h7);
    tick();                                                          // c5
    chk("rd_c5_ack", {31'd0, play_ack}, 32'h0);
    sram_rdata = 16'h5A5A;
    chk("rd_c5_hold", {16'd0, play_rdata}, 32'h1234);

    // Write 0xBEEF to 0x00020
    rec_addr = 20'h00020; rec_wdata = 16'hBEEF; rec_req = 1'b1;
    tick(); rec_req = 1'b0;                                          // c1
    tick();                                                          // c2
    chk("wr_c2_ctrl", {28'd0, ce_n, oe_n, we_n, sram_data_oe}, 32'h5);
    chk("wr_c2_wdata", {16'd0, sram_wdata}, 32'hBEEF);
    tick();                                                          // c3
    chk("wr_c3_we", {30'd0, we_n, sram_data_oe}, 32'h1);
    tick();                                                          // c4
    chk("wr_c4_ack", {31'd0, rec_ack}, 32'h1);
    chk("wr_c4_end", {12'd0, rec_end}, 32'h00021);
    chk("wr_c4_pins_off", {30'd0, we_n, sram_data_oe}, 32'h2);
    tick();
    chk("wr_c5_ack", {31'd0, rec_ack}, 32'h0);

    // EOF boundary around end address 0x00021
    play_addr = 20'h00020; play_req = 1'b1;
    tick(); play_req = 1'b0; tick(); tick(); tick();                 // c4
    chk("eof_0x20_ack", {31'd0, play_ack}, 32'h1);
    chk("eof_0x20", {31'd0, play_eof}, 32'h0);
    play_addr = 20'h00021; play_req = 1'b1;                          // c4 = new c0
    tick(); play_req = 1'b0; tick(); tick(); tick();
    chk("eof_0x21_ack", {31'd0, play_ack}, 32'h1);
    chk("eof_0x21", {31'd0, play_eof}, 32'h1);
    tick();
    chk("eof_pulse_end", {31'd0, play_eof}, 32'h0);
    clr_end = 1'b1;
    tick(); clr_end = 1'b0;
    chk("clr_end", {12'd0, rec_end}, 32'h0);

    // Contention: both at c0, REC first, PLAY second
    rec_addr = 20'h00030; rec_wdata = 16'h1111; rec_req = 1'b1;
    play_addr = 20'h00005; play_req = 1'b1;
    tick(); rec_req = 1'b0; play_req = 1'b0; tick(); tick(); tick(); // c4
    chk("con1_c4_acks", {30'd0, rec_ack, play_ack}, 32'h2);
    chk("con1_c4_end", {12'd0, rec_end}, 32'h00031);
    tick();                                                          // c5
    chk("con1_c5_addr", {12'd0, sram_addr}, 32'h00005);
    tick(); tick();                                                  // c7
    chk("con1_c7_acks", {30'd0, rec_ack, play_ack}, 32'h1);
    chk("con1_c7_eof", {31'd0, play_eof}, 32'h0);
    tick(); tick();

    // Contention again with REC re-requesting at c2 while PLAY still waits
    rec_addr = 20'h00010; rec_wdata = 16'h2222; rec_req = 1'b1;
    play_addr = 20'h00031; play_req = 1'b1;
    tick(); rec_req = 1'b0; play_req = 1'b0;                         // c1
    tick();                                                          // c2
    rec_addr = 20'h00050; rec_wdata = 16'h3333; rec_req = 1'b1;
    tick(); rec_req = 1'b0; tick();                                  // c4
    chk("con2_c4_acks", {30'd0, rec_ack, play_ack}, 32'h2);
    chk("con2_c4_end", {12'd0, rec_end}, 32'h00031);
    tick(); tick(); tick();                                          // c7
`ifdef AUD_ARB_REC_PRIO_EN
    chk("con2_c7_acks", {30'd0, rec_ack, play_ack}, 32'h2);
    chk("con2_c7_end", {12'd0, rec_end}, 32'h00051);
    tick(); tick(); tick();                                          // c10
    chk("con2_c10_acks", {30'd0, rec_ack, play_ack}, 32'h1);
    chk("con2_c10_eof", {31'd0, play_eof}, 32'h0);
`else
    chk("con2_c7_acks", {30'd0, rec_ack, play_ack}, 32'h1);
    chk("con2_c7_eof", {31'd0, play_eof}, 32'h1);
    tick(); tick(); tick();                                          // c10
    chk("con2_c10_acks", {30'd0, rec_ack, play_ack}, 32'h2);
    chk("con2_c10_end", {12'd0, rec_end}, 32'h00051);
`endif
    tick();

    // Write to the top address wraps the end address to 0
    rec_addr = 20'hFFFFF; rec_wdata = 16'h4444; rec_req = 1'b1;
    tick(); rec_req = 1'b0; tick(); tick(); tick();                  // c4
    chk("wrap_ack", {31'd0, rec_ack}, 32'h1);
    chk("wrap_end", {12'd0, rec_end}, 32'h0);
    tick();

    // Second pulse while pending is dropped
    sram_rdata = 16'h0707; play_addr = 20'h00007; play_req = 1'b1;
    tick(); play_addr = 20'h00009;                                   // c1, still pending
    tick(); play_req = 1'b0;                                         // c2
    chk("drop_addr", {12'd0, sram_addr}, 32'h00007);
    tick(); tick();                                                  // c4
    chk("drop_ack", {31'd0, play_ack}, 32'h1);
    tick();                                                          // c5
    chk("drop_no_second", {31'd0, ce_n}, 32'h1);
    tick();

    // Reset in the middle of a write access
    rec_addr = 20'h00060; rec_wdata = 16'h6666; rec_req = 1'b1;
    tick(); rec_req = 1'b0; tick();                                  // c2
    chk("rstw_c2_we", {31'd0, we_n}, 32'h0);
    tick(); rst = 1'b1;                                              // c3
    tick(); rst = 1'b0;                                              // c4
    chk("rstw_c4_ctrl", {28'd0, ce_n, oe_n, we_n, sram_data_oe}, 32'hE);
    chk("rstw_c4_ack", {31'd0, rec_ack}, 32'h0);
    tick();                                                          // c5
    chk("rstw_c5_ack", {31'd0, rec_ack}, 32'h0);
    tick();                                                          // c6
    chk("rstw_c6_idle", {31'd0, ce_n}, 32'h1);

    // Fresh read after reset completes normally (bounded wait)
    sram_rdata = 16'hCAFE; play_addr = 20'h00002; play_req = 1'b1;
    tick(); play_req = 1'b0;
    k = 0;
    while (!play_ack && k < 20) begin
      tick();
      k++;
    end
    chk("post_rst_ack", {31'd0, play_ack}, 32'h1);
    chk("post_rst_lat", k, 32'd3);
    chk("post_rst_rdata", {16'd0, play_rdata}, 32'hCAFE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
